// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - opcodes and FSM state encoding for the shared shift unit
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/shift_datapath.sv
// rtl/shift_datapath.sv - combinational log-stage shifter with saturation override
module shift_datapath
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         err
);

    logic [AW:0][N-1:0] stage;
    logic               shift_left;
    logic               fill;
    logic               sat;

    assign shift_left = (op == OP_SLL);
    assign fill       = (op == OP_SRA) ? a[N-1] : 1'b0;
    // Any bit above the low AW bits means the amount is N or more.
    assign sat        = |b[N-1:AW];
    assign stage[0]   = a;

    // Stage i shifts by 2**i when amount bit i is set.
    for (genvar i = 0; i < AW; i++) begin : g_stage
        localparam int SH = 1 << i;
        logic [N-1:0] shl;
        logic [N-1:0] shr;
        assign shl          = stage[i] << SH;
        assign shr          = {{SH{fill}}, stage[i][N-1:SH]};
        assign stage[i+1]   = b[i] ? (shift_left ? shl : shr) : stage[i];
    end

    // Final selection: reserved opcode and saturation override the stage output.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_SLL, OP_SRL: result = sat ? '0 : stage[AW];
            OP_SRA:         result = sat ? {N{a[N-1]}} : stage[AW];
            default: begin
                result = '0;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin arbiter sharing one shifter between two requesters
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err
);

    logic [1:0]   state;
    logic         last_grant;
    logic [1:0]   lat_op;
    logic [N-1:0] lat_a;
    logic [N-1:0] lat_b;
    logic         lat_id;

    logic         grant_id;
    logic         accept;
    logic [1:0]   sel_op;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [N-1:0] dp_result;
    logic         dp_err;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Readies only in IDLE and out of reset, so they read 0 while rst_n is held low.
    assign req0_ready = rst_n && (state == ST_IDLE) && req0_valid && !grant_id;
    assign req1_ready = rst_n && (state == ST_IDLE) && req1_valid &&  grant_id;
    assign accept     = req0_ready || req1_ready;

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;

    shift_datapath #(
        .N  (N),
        .AW (AW)
    ) u_datapath (
        .op     (lat_op),
        .a      (lat_a),
        .b      (lat_b),
        .result (dp_result),
        .err    (dp_err)
    );

    // Control FSM: accept in IDLE, register the result in EXEC, hold it in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            lat_op     <= 2'b00;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_op     <= sel_op;
                        lat_a      <= sel_a;
                        lat_b      <= sel_b;
                        lat_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= dp_result;
                    rsp_err   <= dp_err;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    logic       model_last;
    logic [7:0] exp_data;
    logic       exp_err;
    logic       exp_id;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    function automatic logic [7:0] ref_data(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        int               amt;
        logic [15:0]      wide;
        logic signed [7:0] sa;
        logic signed [7:0] sr;
        amt  = int'(b);
        wide = {8'h00, a};
        sa   = a;
        if (op == 2'b11) return 8'h00;
        if (op == 2'b10) begin
            if (amt >= 8) return {8{a[7]}};
            sr = sa >>> amt;
            return sr;
        end
        if (amt >= 8) return 8'h00;
        if (op == 2'b00) begin
            wide = wide << amt;
            return wide[7:0];
        end
        return a >> amt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Called at a negedge with requests driven; takes the op through to RESP.
    task automatic complete(input int id, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b);
        #1;
        chk("ready_granted", (id == 0) ? req0_ready : req1_ready, 1);
        chk("ready_other", (id == 0) ? req1_ready : req0_ready, 0);
        exp_data   = ref_data(op, a, b);
        exp_err    = (op == 2'b11);
        exp_id     = id[0];
        model_last = id[0];
        @(posedge clk); @(negedge clk); #1;
        chk("exec_no_valid", rsp_valid, 0);
        chk("exec_no_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_err", rsp_err, exp_err);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    task automatic single(input int id, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b);
        set_req(id, op, a, b);
        complete(id, op, a, b);
        consume();
    endtask

    initial begin
        int         gid;
        int         waited;
        int         hold;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'h22; req1_b = 8'h01;
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness from reset: continuous tie, expected grants 0,1,0,1.
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h33; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'h33; req1_b = 8'h01;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            #1;
            while (!(req0_ready || req1_ready) && waited < 8) begin
                chk("never_both_ready", req0_ready & req1_ready, 0);
                @(negedge clk); #1;
                waited++;
            end
            if (waited >= 8) begin
                checks++;
                failures++;
                $error("FAIL fair_timeout observed=no_grant expected=grant");
            end
            chk("fair_single_ready", req0_ready & req1_ready, 0);
            gid = model_last ? 0 : 1;
            chk("fair_order", req1_ready, k % 2);
            chk("fair_model", req1_ready, gid);
            exp_data   = (gid == 0) ? ref_data(2'b00, 8'h33, 8'h01) : ref_data(2'b01, 8'h33, 8'h01);
            model_last = gid[0];
            @(posedge clk); @(negedge clk);
            @(posedge clk); @(negedge clk); #1;
            chk("fair_rsp_id", rsp_id, gid);
            chk("fair_rsp_data", rsp_data, exp_data);
            @(posedge clk); @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        // Directed shifts and saturation.
        single(0, 2'b10, 8'hB4, 8'd2);
        chk("sra_b4_2", exp_data, 8'hED);
        single(0, 2'b01, 8'hB4, 8'd3);
        single(1, 2'b00, 8'h0F, 8'd4);
        single(0, 2'b10, 8'h7F, 8'd0);
        single(1, 2'b10, 8'h80, 8'd9);
        single(0, 2'b01, 8'h80, 8'd200);
        single(1, 2'b00, 8'hFF, 8'd8);
        single(0, 2'b10, 8'h40, 8'd255);
        single(1, 2'b11, 8'hAA, 8'd1);
        single(1, 2'b01, 8'hAA, 8'd1);

        // Backpressure: hold RESP for 5 cycles with req1 pending.
        rsp_ready = 1'b0;
        set_req(0, 2'b00, 8'h5A, 8'd3);
        complete(0, 2'b00, 8'h5A, 8'd3);
        set_req(1, 2'b10, 8'hC3, 8'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, exp_data);
            chk("bp_id", rsp_id, exp_id);
            chk("bp_err", rsp_err, exp_err);
            chk("bp_ready", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        complete(1, 2'b10, 8'hC3, 8'd2);
        consume();

        // Randomized single requests with random response backpressure.
        for (int n = 0; n < 30; n++) begin
            gid  = int'($urandom_range(0, 1));
            rop  = 2'($urandom_range(0, 3));
            ra   = 8'($urandom);
            rb   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 2));
            rsp_ready = (hold == 0);
            set_req(gid, rop, ra, rb);
            complete(gid, rop, ra, rb);
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); @(negedge clk); #1;
                chk("rand_hold_valid", rsp_valid, 1);
                chk("rand_hold_data", rsp_data, exp_data);
            end
            consume();
        end

        // Reset during EXEC.
        set_req(1, 2'b00, 8'h01, 8'd1);
        @(posedge clk); #2;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk); #1;
            chk("rst_exec_no_stale", rsp_valid, 0);
        end

        // Reset during RESP while the result is held.
        rsp_ready = 1'b0;
        set_req(1, 2'b10, 8'hF0, 8'd1);
        complete(1, 2'b10, 8'hF0, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", rsp_valid, 0);
        chk("rst_resp_data", rsp_data, 0);
        chk("rst_resp_id", rsp_id, 0);
        chk("rst_resp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_resp_no_stale", rsp_valid, 0);
        @(negedge clk);
        set_req(0, 2'b01, 8'h9C, 8'd2);
        set_req(1, 2'b00, 8'h9C, 8'd2);
        complete(0, 2'b01, 8'h9C, 8'd2);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
